// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: drives an external 4-bit adder one nibble per clock to add two wide operands.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [4*NIBBLES-1:0]   x_i,
   input  logic [4*NIBBLES-1:0]   y_i,
   input  logic                   cin_i,
   output logic [3:0]             add_a_o,
   output logic [3:0]             add_b_o,
   output logic                   add_cin_o,
   input  logic [3:0]             add_s_i,
   input  logic                   add_cout_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [4*NIBBLES-1:0]   sum_o,
   output logic                   cout_o,
   output logic                   ovf_o
);
   localparam int W = 4 * NIBBLES;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
   logic [1:0]   state_q, state_d;
   logic [3:0]   idx_q;
   logic         carry_q, cout_q, ovf_q, ovf_d, last;
   logic [W-1:0] xr_q, yr_q, sum_r_q, sum_d, sum_q;
   logic [5:0]   bit_idx;
   assign bit_idx = {idx_q, 2'b00};
   always_comb begin
      last = idx_q == 4'(NIBBLES - 1);
      sum_d = sum_r_q;
      sum_d[bit_idx +: 4] = add_s_i;
      ovf_d = (xr_q[W-1] == yr_q[W-1]) && (sum_d[W-1] != xr_q[W-1]);
      state_d = (state_q == IDLE && start_i) ? RUN :
                (state_q == RUN && last)     ? FIN :
                (state_q == FIN)             ? IDLE : state_q;
   end
   // Results commit on the last RUN edge so they are already valid while DONE is high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         xr_q    <= '0;
         yr_q    <= '0;
         sum_r_q <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start_i) begin
            xr_q    <= x_i;
            yr_q    <= y_i;
            carry_q <= cin_i;
            idx_q   <= '0;
         end
         if (state_q == RUN) begin
            sum_r_q <= sum_d;
            carry_q <= add_cout_i;
            idx_q   <= idx_q + 4'd1;
            if (last) begin
               sum_q  <= sum_d;
               cout_q <= add_cout_i;
               ovf_q  <= ovf_d;
            end
         end
      end
   end
   assign busy_o    = state_q == RUN;
   assign done_o    = state_q == FIN;
   assign add_a_o   = busy_o ? xr_q[bit_idx +: 4] : 4'd0;
   assign add_b_o   = busy_o ? yr_q[bit_idx +: 4] : 4'd0;
   assign add_cin_o = busy_o & carry_q;
   assign sum_o     = sum_q;
   assign cout_o    = cout_q;
   assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors and corner sequences against a behavioural 4-bit adder.
module tb_nibble_serial_adder;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
   logic [15:0] x = '0, y = '0, sum;
   logic [3:0]  add_a, add_b, add_s;
   logic        add_cin, add_cout, busy, done, cout, ovf;
   int          n_chk = 0, n_fail = 0;
   typedef struct {
      logic [15:0] x, y;
      logic        cin;
      logic [15:0] sum;
      logic        cout, ovf;
   } vec_t;
   vec_t vecs[8];
   always #5 clk = ~clk;
   assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);
   nibble_serial_adder #(.NIBBLES(4)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .x_i(x), .y_i(y), .cin_i(cin),
      .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin), .add_s_i(add_s), .add_cout_i(add_cout),
      .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout), .ovf_o(ovf)
   );
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [3:0] carry_seq(input logic [15:0] a, input logic [15:0] b, input logic c);
      logic [3:0] s;
      logic       k;
      k = c;
      for (int i = 0; i < 4; i++) begin
         s[i] = k;
         k = (5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(k)) > 5'd15;
      end
      return s;
   endfunction
   // Drives one START, then follows the operation until DONE; all sampling on the falling edge.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output int lat, output int nbusy, output logic [3:0] seq);
      @(negedge clk);
      start = 1'b1; x = a; y = b; cin = c;
      @(negedge clk);
      start = 1'b0; x = $urandom; y = $urandom; cin = 1'($urandom);
      lat = 1; nbusy = 0; seq = '0;
      while (!done && lat < 20) begin
         if (busy) begin
            if (nbusy < 4) seq[nbusy] = add_cin;
            nbusy++;
         end
         @(negedge clk);
         lat++;
      end
   endtask
   initial begin
      int         lat, nbusy, ndone, acc;
      logic [3:0] seq;
      logic [15:0] ex;
      vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[7] = '{16'h89AB, 16'h7655, 1'b0, 16'h0000, 1'b1, 1'b0};
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_outs", {busy, done, sum, cout, ovf, add_a, add_b, add_cin}, '0);
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].x, vecs[i].y, vecs[i].cin, lat, nbusy, seq);
         check($sformatf("v%0d_latency", i), lat, 5);
         check($sformatf("v%0d_busy_cycles", i), nbusy, 4);
         check($sformatf("v%0d_cin_seq", i), seq, carry_seq(vecs[i].x, vecs[i].y, vecs[i].cin));
         check($sformatf("v%0d_result", i), {sum, cout, ovf}, {vecs[i].sum, vecs[i].cout, vecs[i].ovf});
         check($sformatf("v%0d_busy_done", i), busy, 0);
         @(negedge clk);
         check($sformatf("v%0d_done_single", i), {done, busy}, 2'b00);
      end
      check("ripple_cin_seq", carry_seq(16'hFFFF, 16'h0001, 1'b0), 4'b1110);
      // START during RUN must be ignored.
      @(negedge clk);
      start = 1'b1; x = 16'h1234; y = 16'h1111; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; x = 16'hFFFF;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) begin
            ndone++;
            check("ignore_sum", sum, 16'h2345);
         end
         @(negedge clk);
      end
      check("ignore_done_count", ndone, 1);
      // Reset in the third RUN cycle discards the operation.
      start = 1'b1; x = 16'hFFFF; y = 16'hFFFF; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun_reset_outs", {busy, done, sum, cout, ovf, add_a, add_b, add_cin}, '0);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         ndone += int'(done) + int'(busy);
         @(negedge clk);
      end
      check("no_done_after_reset", ndone, 0);
      do_op(16'hFFFF, 16'hFFFF, 1'b1, lat, nbusy, seq);
      check("post_reset_latency", lat, 5);
      check("post_reset_result", {sum, cout}, {16'hFFFF, 1'b1});
      @(negedge clk);
      // START held high: accepted at cycles 0, 6, 12; DONE sampled 5 cycles later.
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         check($sformatf("b2b_done_c%0d", c), done, (c >= 5 && c % 6 == 5));
         check($sformatf("b2b_excl_c%0d", c), busy & done, 0);
         if (c >= 5 && c % 6 == 5) begin
            acc = c - 5;
            ex = 16'(acc * 16'h0123) + 16'(16'hF00F - acc * 3);
            check($sformatf("b2b_sum_c%0d", c), sum, ex);
         end
         start = 1'b1; cin = 1'b0;
         x = 16'(c * 16'h0123);
         y = 16'(16'hF00F - c * 3);
         @(negedge clk);
      end
      start = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
